// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the 74HC165 chain reader: FSM state encoding
// and divider defaults.
package shift_reg_pkg;

  localparam int DEFAULT_CLK_DIV = 1;
  localparam int DIV_CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_DONE
  } state_t;

  // The timer counts reload..0 inclusive, so a phase of N cycles reloads with N-1.
  function automatic logic [DIV_CNT_W-1:0] div_reload(input int clk_div);
    return DIV_CNT_W'(clk_div - 1);
  endfunction

endpackage

// File: rtl/half_period_timer.sv
// Down-counter that times one LOAD/SETTLE/CLK_HI/CLK_LO phase of CLK_DIV cycles;
// done_o is the terminal-count compare and is high on the last cycle of a phase.
module half_period_timer
  import shift_reg_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic done_o
);

  localparam logic [DIV_CNT_W-1:0] RELOAD = div_reload(CLK_DIV);

  logic [DIV_CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done_o = (cnt == '0);

endmodule

// File: rtl/shift_in_165_reader.sv
// Reads a chain of NUM_ICS daisy-chained 74HC165s into one W-bit word per trigger.
// Optional changed_o output is enabled with SHIFT_IN_165_CHANGE_DETECT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for trigger_i, PL high, CP low
// ST_LOAD   | PL low, chips latch parallel inputs
// ST_SETTLE | PL high, first bit sampled on last cycle
// ST_CLK_HI | CP high, chain shifts by one
// ST_CLK_LO | CP low, next bit sampled on last cycle
// ST_DONE   | word presented on data_o with valid_o
module shift_in_165_reader
  import shift_reg_pkg::*;
#(
  parameter int NUM_ICS = 2,
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  localparam int W      = NUM_ICS * 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         trigger_i,
  input  logic         serial_i,
  output logic         pl_n_o,
  output logic         sclk_o,
  output logic         busy_o,
  output logic         valid_o,
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
  output logic         changed_o,
`endif
  output logic [W-1:0] data_o
);

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [W-1:0]    shreg;
  logic [W-1:0]    shift_next;
  logic            tmr_load;
  logic            tmr_done;

  assign shift_next = {shreg[W-2:0], serial_i};

  // Reload the timer on every transition into a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    case (state)
      ST_IDLE:   tmr_load = trigger_i;
      ST_LOAD,
      ST_SETTLE,
      ST_CLK_HI: tmr_load = tmr_done;
      ST_CLK_LO: tmr_load = tmr_done && (bit_cnt != LAST_BIT);
      default:   tmr_load = 1'b0;
    endcase
  end

  half_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tmr_load),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      pl_n_o    <= 1'b1;
      sclk_o    <= 1'b0;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
      changed_o <= 1'b0;
`endif
    end else begin
      valid_o   <= 1'b0;
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
      changed_o <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (trigger_i) begin
            state   <= ST_LOAD;
            bit_cnt <= '0;
            pl_n_o  <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (tmr_done) begin
            state  <= ST_SETTLE;
            pl_n_o <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_done) begin
            shreg   <= shift_next;
            bit_cnt <= bit_cnt + 1'b1;
            state   <= ST_CLK_HI;
            sclk_o  <= 1'b1;
          end
        end
        ST_CLK_HI: begin
          if (tmr_done) begin
            state  <= ST_CLK_LO;
            sclk_o <= 1'b0;
          end
        end
        ST_CLK_LO: begin
          if (tmr_done) begin
            shreg <= shift_next;
            if (bit_cnt == LAST_BIT) begin
              // The last sample goes straight to data_o so it is visible in DONE.
              state     <= ST_DONE;
              data_o    <= shift_next;
              valid_o   <= 1'b1;
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
              changed_o <= (shift_next != data_o);
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= ST_CLK_HI;
              sclk_o  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          pl_n_o <= 1'b1;
          sclk_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_in_165_reader.sv
// Bench for shift_in_165_reader: two instances (CLK_DIV=1 and 3) driven by 165-chain
// models, checked every cycle against a cycle-count phase model plus directed cases.
module tb_shift_in_165_reader;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic trig1, trig3, ser1, ser3, pl1, pl3, sc1, sc3, busy1, busy3, val1, val3;
  logic [W-1:0] data1, data3;
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
  logic ch1, ch3;
`endif

  shift_in_165_reader #(.NUM_ICS(2), .CLK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig1), .serial_i(ser1),
    .pl_n_o(pl1), .sclk_o(sc1), .busy_o(busy1), .valid_o(val1),
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
    .changed_o(ch1),
`endif
    .data_o(data1));

  shift_in_165_reader #(.NUM_ICS(2), .CLK_DIV(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig3), .serial_i(ser3),
    .pl_n_o(pl3), .sclk_o(sc3), .busy_o(busy3), .valid_o(val3),
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
    .changed_o(ch3),
`endif
    .data_o(data3));

  // Chain of two 165s: PL low loads asynchronously, CP rise shifts toward Q7.
  logic [W-1:0] par1, par3;
  logic [W-1:0] chain1 = '0, chain3 = '0;
  always @(posedge sc1 or negedge pl1)
    if (!pl1) chain1 <= par1; else chain1 <= {chain1[W-2:0], 1'b0};
  always @(posedge sc3 or negedge pl3)
    if (!pl3) chain3 <= par3; else chain3 <= {chain3[W-2:0], 1'b0};
  assign ser1 = chain1[W-1];
  assign ser3 = chain3[W-1];

  int rises1 = 0, rises3 = 0;
  always @(posedge sc1) rises1++;
  always @(posedge sc3) rises3++;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the accepting edge (0 = idle); a read lasts 2*D*W+1 cycles.
  int             phase[2];
  logic [W-1:0]   cap[2];
  logic [W-1:0]   exp_data[2];
  logic           exp_chg[2];
  int             dv[2] = '{1, 3};

  task automatic cmp_inst(input string tag, input int k, input int d, input logic [W-1:0] ed,
                          input logic pl, input logic sc, input logic bz, input logic vl,
                          input logic [W-1:0] dt);
    int n, m;
    logic e_pl, e_sc;
    n    = 2 * d * W + 1;
    m    = k - 2 * d - 1;
    e_pl = !(k >= 1 && k <= d);
    e_sc = (k > 0) && (m >= 0) && (m < 2 * d * (W - 1)) && ((m % (2 * d)) < d);
    check({tag, ".pl_n"},  32'(pl), 32'(e_pl));
    check({tag, ".sclk"},  32'(sc), 32'(e_sc));
    check({tag, ".busy"},  32'(bz), 32'(k != 0));
    check({tag, ".valid"}, 32'(vl), 32'(k == n));
    check({tag, ".data"},  32'(dt), 32'(ed));
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic         t;
      logic [W-1:0] p;
      int           n;
      t = (i == 0) ? trig1 : trig3;
      p = (i == 0) ? par1 : par3;
      n = 2 * dv[i] * W + 1;
      if (rst) begin
        phase[i] = 0; exp_data[i] = '0; exp_chg[i] = 1'b0;
      end else if (phase[i] == 0) begin
        if (t) begin phase[i] = 1; cap[i] = p; end
      end else if (phase[i] == n) begin
        phase[i] = 0;
      end else begin
        phase[i]++;
        if (phase[i] == n) begin
          exp_chg[i]  = (cap[i] != exp_data[i]);
          exp_data[i] = cap[i];
        end
      end
    end
    #3;
    cmp_inst("d1", phase[0], 1, exp_data[0], pl1, sc1, busy1, val1, data1);
    cmp_inst("d3", phase[1], 3, exp_data[1], pl3, sc3, busy3, val3, data3);
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
    check("d1.changed", 32'(ch1), 32'(phase[0] == 33 && exp_chg[0]));
    check("d3.changed", 32'(ch3), 32'(phase[1] == 97 && exp_chg[1]));
`endif
  end

  // One triggered read on dut1; returns cycles from acceptance to valid_o.
  task automatic read1(input logic [W-1:0] v, output int lat);
    par1 = v;
    @(negedge clk) trig1 = 1'b1;
    @(negedge clk) trig1 = 1'b0;
    lat = 1;
    while (!val1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0, pl_low, sc_hi, nval, gap;
    logic busy_drop;
    logic [W-1:0] words[3];
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
    logic exp_c[3];
    exp_c = '{1'b0, 1'b1, 1'b0};
`endif
    words = '{16'h0000, 16'h1234, 16'h1234};
    rst = 1'b1; trig1 = 1'b0; trig3 = 1'b0; par1 = '0; par3 = '0;
    repeat (3) @(negedge clk);
    check("reset.pl_n",  32'(pl1),   32'd1);
    check("reset.sclk",  32'(sc1),   32'd0);
    check("reset.busy",  32'(busy1), 32'd0);
    check("reset.valid", 32'(val1),  32'd0);
    check("reset.data",  32'(data1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Three reads straight after reset; change flag compares against 0 first.
    for (int i = 0; i < 3; i++) begin
      read1(words[i], lat);
      check("seq.lat",  32'(lat),   32'd33);
      check("seq.data", 32'(data1), 32'(words[i]));
`ifdef SHIFT_IN_165_CHANGE_DETECT_EN
      check("seq.changed", 32'(ch1), 32'(exp_c[i]));
`endif
    end

    r0 = rises1;
    read1(16'hA5C3, lat);
    check("a5c3.lat",   32'(lat),         32'd33);
    check("a5c3.data",  32'(data1),       32'hA5C3);
    check("a5c3.rises", 32'(rises1 - r0), 32'd15);

    // CLK_DIV=3 instance: phase lengths and latency.
    par3 = 16'h8001;
    r0 = rises3;
    @(negedge clk) trig3 = 1'b1;
    @(negedge clk) trig3 = 1'b0;
    lat = 1; pl_low = 0; sc_hi = 0;
    while (!val3 && lat < 1000) begin
      if (!pl3) pl_low++;
      if (sc3) sc_hi++;
      @(negedge clk);
      lat++;
    end
    check("div3.lat",    32'(lat),         32'd97);
    check("div3.pl_low", 32'(pl_low),      32'd3);
    check("div3.sc_hi",  32'(sc_hi),       32'd45);
    check("div3.rises",  32'(rises3 - r0), 32'd15);
    check("div3.data",   32'(data3),       32'h8001);

    // Trigger pulsed during CLK_HI is ignored.
    par1 = 16'h3C96;
    @(negedge clk) trig1 = 1'b1;
    @(negedge clk) trig1 = 1'b0;
    lat = 0;
    while (!sc1 && lat < 50) begin @(negedge clk); lat++; end
    trig1 = 1'b1;
    @(negedge clk) trig1 = 1'b0;
    nval = 0; busy_drop = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (val1) begin
        nval++;
        check("ign.data", 32'(data1), 32'h3C96);
      end else if (nval == 0 && !busy1) begin
        busy_drop = 1'b1;
      end
      @(negedge clk);
    end
    check("ign.nvalid",    32'(nval),      32'd1);
    check("ign.busy_drop", 32'(busy_drop), 32'd0);

    // Reset during the 8th bit aborts the read.
    par1 = 16'hFFFF;
    r0 = rises1;
    @(negedge clk) trig1 = 1'b1;
    @(negedge clk) trig1 = 1'b0;
    lat = 0;
    while ((rises1 - r0) < 7 && lat < 100) begin @(negedge clk); lat++; end
    rst = 1'b1;
    #1;
    check("abort.pl_n", 32'(pl1),   32'd1);
    check("abort.sclk", 32'(sc1),   32'd0);
    check("abort.data", 32'(data1), 32'd0);
    check("abort.busy", 32'(busy1), 32'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    nval = 0;
    for (int c = 0; c < 60; c++) begin
      if (val1) nval++;
      @(negedge clk);
    end
    check("abort.nvalid", 32'(nval), 32'd0);

    // Random triggers; the per-cycle model covers ignored triggers and data.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (val1) par1 = W'($urandom);
      if (val3) par3 = W'($urandom);
      trig1 = ($urandom_range(0, 2) == 0);
      trig3 = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk) begin trig1 = 1'b0; trig3 = 1'b0; end
    repeat (200) @(negedge clk);

    // Trigger held high: back-to-back reads.
    trig1 = 1'b1;
    lat = 0;
    while (!val1 && lat < 100) begin @(negedge clk); lat++; end
    @(negedge clk);
    gap = 1;
    while (!val1 && gap < 100) begin @(negedge clk); gap++; end
    check("b2b.gap", 32'(gap), 32'd34);
    trig1 = 1'b0;
    repeat (80) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/shift_in_165_reader.md
SHIFT_IN_165_READER -- requirements
Module: shift_in_165_reader

Interface
REQ-001 Parameter NUM_ICS, default 2, number of daisy-chained 74HC165s; word width W = NUM_ICS*8.
REQ-002 Parameter CLK_DIV, default 1, clk_i cycles per half-period of sclk_o and per load/settle phase; legal range 1..255.
REQ-003 clk_i  input  1  single block clock; all logic on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 trigger_i  input  1  active-high read request, sampled in IDLE only.
REQ-006 serial_i  input  1  Q7 of last 165 in chain.
REQ-007 pl_n_o  output  1  PL (parallel load, active-low) to all 165s.
REQ-008 sclk_o  output  1  CP to all 165s (CE tied low on board).
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 valid_o  output  1  one-cycle pulse: new word on data_o.
REQ-011 data_o  output  W  last completed word, first-sampled bit in data_o[W-1].

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SETTLE, CLK_HI, CLK_LO, DONE.
REQ-013 IDLE: pl_n_o=1, sclk_o=0; trigger_i=1 -> LOAD, bit counter cleared.
REQ-014 LOAD: pl_n_o=0 for CLK_DIV cycles -> SETTLE.
REQ-015 SETTLE: pl_n_o=1 for CLK_DIV cycles; on last cycle's edge shift serial_i into shift-register LSB (register shifts left) -> CLK_HI.
REQ-016 CLK_HI: sclk_o=1 for CLK_DIV cycles -> CLK_LO.
REQ-017 CLK_LO: sclk_o=0 for CLK_DIV cycles; on last cycle sample serial_i as in REQ-015; after W-th sample -> DONE, else -> CLK_HI.
REQ-018 Exactly W samples and W-1 sclk_o rising edges per read.
REQ-019 DONE: one cycle; data_o <= shift register, valid_o=1 -> IDLE.
REQ-020 Latency: trigger accepted at edge ending cycle T -> valid_o high in cycle T+2*CLK_DIV*W+1.
REQ-021 trigger_i outside IDLE (including DONE) SHALL be ignored, no queuing.
REQ-022 data_o SHALL change only in DONE; stable otherwise.
REQ-023 Bit counter width clog2(W); divider counter width 8 bits; no wrap beyond W-1.
REQ-024 trigger_i held high continuously SHALL produce back-to-back reads with one IDLE cycle between DONE and LOAD.

Reset
REQ-025 rst_i asserted SHALL immediately force IDLE, pl_n_o=1, sclk_o=0, busy_o=0, valid_o=0, data_o=0, counters and shift register 0.
REQ-026 Reset mid-read SHALL abort with no valid_o pulse; data_o cleared.

Configuration
REQ-027 Macro SHIFT_IN_165_CHANGE_DETECT_EN defined: extra output changed_o (1 bit) pulses with valid_o when new word differs from previous data_o (first read after reset compares to 0); changed_o reset 0.
REQ-028 Macro undefined: no changed_o port, no comparison register.

Structure
REQ-029 Shared package shift_reg_pkg SHALL hold the FSM state enum and constant DEFAULT_CLK_DIV.
REQ-030 Sub-module half_period_timer (load, count down, done strobe) SHALL time LOAD/SETTLE/CLK_HI/CLK_LO phases.

Verification
REQ-031 NUM_ICS=2, CLK_DIV=1, 165 model loaded 16'hA5C3, trigger pulse -> valid_o at T+33, data_o=16'hA5C3, 15 sclk_o rises.
REQ-032 CLK_DIV=3, model 16'h8001 -> pl_n_o low 3 cycles, sclk_o high/low 3 cycles each, valid_o at T+97, data_o=16'h8001.
REQ-033 trigger_i pulsed during CLK_HI of an active read -> single valid_o, busy_o stays high until DONE.
REQ-034 rst_i asserted during 8th bit -> pl_n_o=1, sclk_o=0, data_o=0 same cycle, no valid_o.
REQ-035 CHANGE_DETECT_EN, reads 16'h0000, 16'h1234, 16'h1234 -> changed_o 0,1,0.
REQ-036 trigger_i held high -> consecutive valid_o pulses 34 cycles apart (CLK_DIV=1, NUM_ICS=2).
